led_scan_rx: RTL and testbench

//  Receiver/monitor for the 6-digit multiplexed 7-segment scan bus (seg, dp, active-low enb).

---
 rtl/led_scan_rx.sv | 278 +++++++++++++++++++++++++++
 tb/tb_led_scan_rx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/led_scan_rx.sv
// led_scan_rx: rebuilds the static 6-digit image from a multiplexed 7-segment scan bus.
// Build option LED_SCAN_RX_SYNC_EN inserts a 2-FF synchronizer ahead of the input stage.
module led_scan_rx #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [41:0] o_six_digit_seg,
    output logic [5:0]  o_six_dp,
    output logic [23:0] o_six_num,
    output logic [5:0]  o_dec_err,
    output logic        o_frame_valid,
    output logic        o_seq_err,
    output logic        o_link_up
);
    localparam int unsigned NDIG = 6;
    localparam int unsigned CW   = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [0:0] {ST_WAIT_SYNC, ST_COLLECT} state_t;

    // Segment pattern -> {err, number}; blank maps to E without error
    function automatic logic [4:0] dec7(input logic [6:0] p);
        case (p)
            7'b1111110: dec7 = {1'b0, 4'h0};
            7'b0110000: dec7 = {1'b0, 4'h1};
            7'b1101101: dec7 = {1'b0, 4'h2};
            7'b1111001: dec7 = {1'b0, 4'h3};
            7'b0110011: dec7 = {1'b0, 4'h4};
            7'b1011011: dec7 = {1'b0, 4'h5};
            7'b1011111: dec7 = {1'b0, 4'h6};
            7'b1110000: dec7 = {1'b0, 4'h7};
            7'b1111111: dec7 = {1'b0, 4'h8};
            7'b1110011: dec7 = {1'b0, 4'h9};
            7'b0000000: dec7 = {1'b0, 4'hE};
            default:    dec7 = {1'b1, 4'hF};
        endcase
    endfunction

    logic [6:0] w_seg_in;
    logic       w_dp_in;
    logic [5:0] w_enb_in;

`ifdef LED_SCAN_RX_SYNC_EN
    logic [13:0] r_sync1;
    logic [13:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_seg, i_seg_dp, i_seg_enb};
            r_sync2 <= r_sync1;
        end
    end
    assign {w_seg_in, w_dp_in, w_enb_in} = r_sync2;
`else
    assign w_seg_in = i_seg;
    assign w_dp_in  = i_seg_dp;
    assign w_enb_in = i_seg_enb;
`endif

    logic [6:0]    r_s_seg;
    logic          r_s_dp;
    logic [5:0]    r_s_enb;
    logic [5:0]    r_prev_enb;
    logic [CW-1:0] r_stable_cnt;
    logic [TW-1:0] r_idle_cnt;
    logic [2:0]    r_last_idx;
    logic          r_last_vld;
    logic [6:0]    r_sh_seg [NDIG];
    logic [5:0]    r_sh_dp;
    state_t        r_state;
    logic [2:0]    r_expect;
    logic [41:0]   r_six_digit_seg;
    logic [5:0]    r_six_dp;
    logic [23:0]   r_six_num;
    logic [5:0]    r_dec_err;
    logic          r_frame_valid;
    logic          r_seq_err;
    logic          r_link_up;

    logic [5:0]    w_enb_lo;
    logic          w_valid;
    logic [2:0]    w_idx;
    logic          w_changed;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_capture;
    logic [TW-1:0] w_idle_nxt;
    logic          w_timeout;
    state_t        w_state_nxt;
    logic [2:0]    w_expect_nxt;
    logic          w_link_nxt;
    logic          w_seq_err_nxt;
    logic          w_load;
    logic [41:0]   w_img_seg;
    logic [5:0]    w_img_dp;
    logic [23:0]   w_img_num;
    logic [5:0]    w_img_err;

    // Single register stage; everything downstream runs on these copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_seg <= '0;
            r_s_dp  <= 1'b0;
            r_s_enb <= '0;
        end else begin
            r_s_seg <= w_seg_in;
            r_s_dp  <= w_dp_in;
            r_s_enb <= w_enb_in;
        end
    end

    assign w_enb_lo  = ~r_s_enb;
    assign w_valid   = $onehot(w_enb_lo);
    assign w_changed = (r_s_enb != r_prev_enb);

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (w_enb_lo[k]) w_idx = 3'(k);
        end
    end

    always_comb begin
        w_cnt_nxt = r_stable_cnt;
        if (w_changed)                               w_cnt_nxt = '0;
        else if (r_stable_cnt != CW'(SETTLE_CYC))    w_cnt_nxt = r_stable_cnt + CW'(1);
    end

    // A glitch back to the digit just captured belongs to the same dwell
    assign w_capture = w_valid && (w_cnt_nxt == CW'(SETTLE_CYC - 1))
                       && !(r_last_vld && (r_last_idx == w_idx));

    always_comb begin
        w_idle_nxt = r_idle_cnt;
        if (w_capture)                                   w_idle_nxt = '0;
        else if (r_idle_cnt != TW'(TIMEOUT_CYC - 1))     w_idle_nxt = r_idle_cnt + TW'(1);
    end

    assign w_timeout = !w_capture && (w_idle_nxt == TW'(TIMEOUT_CYC - 1))
                       && (r_idle_cnt != TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_enb   <= '0;
            r_stable_cnt <= '0;
            r_idle_cnt   <= '0;
            r_last_idx   <= '0;
            r_last_vld   <= 1'b0;
        end else begin
            r_prev_enb   <= r_s_enb;
            r_stable_cnt <= w_cnt_nxt;
            r_idle_cnt   <= w_idle_nxt;
            if (w_capture) begin
                r_last_idx <= w_idx;
                r_last_vld <= 1'b1;
            end else if (w_timeout) begin
                r_last_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NDIG; k++) r_sh_seg[k] <= '0;
            r_sh_dp <= '0;
        end else if (w_capture) begin
            r_sh_seg[w_idx] <= r_s_seg;
            r_sh_dp[w_idx]  <= r_s_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT_SYNC;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_expect_nxt  = r_expect;
        w_link_nxt    = r_link_up;
        w_seq_err_nxt = 1'b0;
        w_load        = 1'b0;
        case (r_state)
            ST_WAIT_SYNC: begin
                if (w_capture && (w_idx == 3'd0)) begin
                    w_state_nxt  = ST_COLLECT;
                    w_expect_nxt = 3'd1;
                end
            end
            ST_COLLECT: begin
                if (w_capture) begin
                    if (w_idx == r_expect) begin
                        if (w_idx == 3'd5) begin
                            w_load       = 1'b1;
                            w_link_nxt   = 1'b1;
                            w_state_nxt  = ST_WAIT_SYNC;
                            w_expect_nxt = '0;
                        end else begin
                            w_expect_nxt = r_expect + 3'd1;
                        end
                    end else if (w_idx == 3'd0) begin
                        w_expect_nxt  = 3'd1;
                        w_seq_err_nxt = 1'b1;
                        w_link_nxt    = 1'b0;
                    end else begin
                        w_seq_err_nxt = 1'b1;
                        w_link_nxt    = 1'b0;
                        w_state_nxt   = ST_WAIT_SYNC;
                        w_expect_nxt  = '0;
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_SYNC;
        endcase
        if (w_timeout) begin
            w_link_nxt   = 1'b0;
            w_state_nxt  = ST_WAIT_SYNC;
            w_expect_nxt = '0;
        end
    end

    // Completed image: slots 0..4 from shadow, slot 5 straight from the input stage
    always_comb begin
        w_img_seg = '0;
        w_img_dp  = '0;
        w_img_num = '0;
        w_img_err = '0;
        for (int k = 0; k < NDIG; k++) begin
            w_img_seg[7*k +: 7] = r_sh_seg[k];
            w_img_dp[k]         = r_sh_dp[k];
        end
        w_img_seg[41:35] = r_s_seg;
        w_img_dp[5]      = r_s_dp;
        for (int k = 0; k < NDIG; k++) begin
            {w_img_err[k], w_img_num[4*k +: 4]} = dec7(w_img_seg[7*k +: 7]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expect        <= '0;
            r_six_digit_seg <= '0;
            r_six_dp        <= '0;
            r_six_num       <= '0;
            r_dec_err       <= '0;
            r_frame_valid   <= 1'b0;
            r_seq_err       <= 1'b0;
            r_link_up       <= 1'b0;
        end else begin
            r_expect      <= w_expect_nxt;
            r_frame_valid <= w_load;
            r_seq_err     <= w_seq_err_nxt;
            r_link_up     <= w_link_nxt;
            if (w_load) begin
                r_six_digit_seg <= w_img_seg;
                r_six_dp        <= w_img_dp;
                r_six_num       <= w_img_num;
                r_dec_err       <= w_img_err;
            end
        end
    end

    assign o_six_digit_seg = r_six_digit_seg;
    assign o_six_dp        = r_six_dp;
    assign o_six_num       = r_six_num;
    assign o_dec_err       = r_dec_err;
    assign o_frame_valid   = r_frame_valid;
    assign o_seq_err       = r_seq_err;
    assign o_link_up       = r_link_up;

endmodule

// File: tb/tb_led_scan_rx.sv
// Directed bench for led_scan_rx: frames, decode errors, ordering, glitch, timeout, reset.
module tb_led_scan_rx;
    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1110011;
    localparam logic [6:0] PB = 7'b0000000;
    localparam logic [6:0] PX = 7'b1000001;

    logic        clk;
    logic        rst_n;
    logic [6:0]  i_seg;
    logic        i_seg_dp;
    logic [5:0]  i_seg_enb;
    logic [41:0] o_six_digit_seg;
    logic [5:0]  o_six_dp;
    logic [23:0] o_six_num;
    logic [5:0]  o_dec_err;
    logic        o_frame_valid;
    logic        o_seq_err;
    logic        o_link_up;

    int errors = 0;
    int checks = 0;
    int fv_cnt = 0;
    int se_cnt = 0;

    led_scan_rx #(.SETTLE_CYC(4), .TIMEOUT_CYC(100)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_seg           (i_seg),
        .i_seg_dp        (i_seg_dp),
        .i_seg_enb       (i_seg_enb),
        .o_six_digit_seg (o_six_digit_seg),
        .o_six_dp        (o_six_dp),
        .o_six_num       (o_six_num),
        .o_dec_err       (o_dec_err),
        .o_frame_valid   (o_frame_valid),
        .o_seq_err       (o_seq_err),
        .o_link_up       (o_link_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (o_frame_valid) fv_cnt++;
        if (o_seq_err)     se_cnt++;
    end

    task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic dwell(input int k, input logic [6:0] seg, input logic dp, input int n);
        logic [5:0] one;
        one = 6'b000001;
        @(negedge clk);
        i_seg_enb = ~(one << k);
        i_seg     = seg;
        i_seg_dp  = dp;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan(input logic [41:0] img, input logic [5:0] dp);
        for (int k = 0; k < 6; k++) dwell(k, img[7*k +: 7], dp[k], 50);
    endtask

    initial begin
        rst_n = 1'b0; i_seg = '0; i_seg_dp = 1'b0; i_seg_enb = 6'h3F;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_seg",  42'(o_six_digit_seg), 42'd0);
        chk("rst_num",  42'(o_six_num), 42'd0);
        chk("rst_dp",   42'(o_six_dp), 42'd0);
        chk("rst_link", 42'(o_link_up), 42'd0);

        // Value 37 with dp on digit 1
        scan({PB, PB, PB, PB, P3, P7}, 6'b000010);
        chk("a_num",  42'(o_six_num), 42'hEEEE37);
        chk("a_seg",  o_six_digit_seg, {PB, PB, PB, PB, P3, P7});
        chk("a_dp",   42'(o_six_dp), 42'b000010);
        chk("a_err",  42'(o_dec_err), 42'd0);
        chk("a_link", 42'(o_link_up), 42'd1);
        chk("a_fv",   42'(fv_cnt), 42'd1);
        chk("a_se",   42'(se_cnt), 42'd0);

        // Undecodable pattern on digit 3
        scan({P5, P4, PX, P2, P1, P0}, 6'b000000);
        chk("b_num",  42'(o_six_num), 42'h54F210);
        chk("b_err",  42'(o_dec_err), 42'b001000);
        chk("b_seg",  o_six_digit_seg, {P5, P4, PX, P2, P1, P0});
        chk("b_fv",   42'(fv_cnt), 42'd2);
        chk("b_link", 42'(o_link_up), 42'd1);

        // Out of order 0,1,3
        dwell(0, P6, 1'b0, 50);
        dwell(1, P9, 1'b0, 50);
        dwell(3, P8, 1'b0, 50);
        chk("c_se",   42'(se_cnt), 42'd1);
        chk("c_link", 42'(o_link_up), 42'd0);
        chk("c_num",  42'(o_six_num), 42'h54F210);
        chk("c_fv",   42'(fv_cnt), 42'd2);

        // Short glitch to digit 1 inside the digit-0 dwell
        dwell(0, P8, 1'b0, 20);
        dwell(1, P8, 1'b0, 2);
        dwell(0, P8, 1'b0, 28);
        chk("g_se_mid", 42'(se_cnt), 42'd1);
        dwell(1, PB, 1'b0, 50);
        dwell(2, P9, 1'b0, 50);
        dwell(3, P6, 1'b0, 50);
        dwell(4, P7, 1'b0, 50);
        dwell(5, P1, 1'b0, 50);
        chk("g_se",   42'(se_cnt), 42'd1);
        chk("g_fv",   42'(fv_cnt), 42'd3);
        chk("g_num",  42'(o_six_num), 42'h1769E8);
        chk("g_err",  42'(o_dec_err), 42'd0);
        chk("g_link", 42'(o_link_up), 42'd1);

        // Scan stops: link drops ~100 clk after last capture, frame held
        @(negedge clk);
        i_seg_enb = 6'h3F;
        repeat (40) @(negedge clk);
        chk("t_link_pre",  42'(o_link_up), 42'd1);
        repeat (20) @(negedge clk);
        chk("t_link_post", 42'(o_link_up), 42'd0);
        chk("t_num",       42'(o_six_num), 42'h1769E8);
        chk("t_seg",       o_six_digit_seg, {P1, P7, P6, P9, PB, P8});

        // Reset in the middle of a scan
        dwell(0, P2, 1'b0, 50);
        dwell(1, P2, 1'b0, 50);
        dwell(2, P2, 1'b0, 20);
        rst_n = 1'b0;
        #1;
        chk("r_num",  42'(o_six_num), 42'd0);
        chk("r_seg",  42'(o_six_digit_seg), 42'd0);
        chk("r_link", 42'(o_link_up), 42'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (27) @(negedge clk);
        dwell(3, P2, 1'b0, 50);
        dwell(4, P2, 1'b0, 50);
        dwell(5, P2, 1'b0, 50);
        chk("r_fv_partial",  42'(fv_cnt), 42'd3);
        chk("r_num_partial", 42'(o_six_num), 42'd0);

        scan({P8, P8, P8, P8, P8, P8}, 6'h3F);
        chk("d_fv",   42'(fv_cnt), 42'd4);
        chk("d_num",  42'(o_six_num), 42'h888888);
        chk("d_dp",   42'(o_six_dp), 42'h3F);
        chk("d_link", 42'(o_link_up), 42'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
